// File: rtl/axi_to_mem_r_beat_gen.sv
// Turns one AXI read burst descriptor into a stream of single-word memory reads and
// returns the read data as AXI R beats, with a bounded number of reads in flight.
module axi_to_mem_r_beat_gen #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned UserWidth      = 1,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    input  logic [2:0]           ar_size_i,
    input  logic [1:0]           ar_burst_i,
    input  logic [UserWidth-1:0] ar_user_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    input  logic                 mem_err_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic [UserWidth-1:0] r_user_o
);

    localparam int unsigned PtrWidth  = $clog2(MaxOutstanding);
    localparam int unsigned CntWidth  = PtrWidth + 1;
    localparam int unsigned MetaWidth = IdWidth + UserWidth + 1;
    localparam int unsigned RespWidth = DataWidth + 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    state_e state_q, state_d;

    logic [IdWidth-1:0]   id_q;
    logic [AddrWidth-1:0] addr_q;
    logic [7:0]           len_q;
    logic [7:0]           beat_cnt_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic [UserWidth-1:0] user_q;
    logic [CntWidth-1:0]  outstanding_q;

    logic ar_hs;
    logic issue;
    logic r_hs;
    logic can_issue;

    logic [AddrWidth-1:0] addr_step;
    logic [AddrWidth-1:0] addr_incr;
    logic [AddrWidth-1:0] wrap_mask;
    logic [AddrWidth-1:0] addr_next;

    logic [MetaWidth-1:0] meta_mem [MaxOutstanding];
    logic [PtrWidth-1:0]  meta_wr_q;
    logic [PtrWidth-1:0]  meta_rd_q;
    logic                 meta_last;

    logic [RespWidth-1:0] resp_mem [MaxOutstanding];
    logic [PtrWidth-1:0]  resp_wr_q;
    logic [PtrWidth-1:0]  resp_rd_q;
    logic [CntWidth-1:0]  resp_cnt_q;
    logic                 resp_err;

    assign can_issue = (outstanding_q < CntWidth'(MaxOutstanding));
    assign ar_hs     = ar_valid_i && ar_ready_o;
    assign issue     = mem_req_o && mem_gnt_i;
    assign r_hs      = r_valid_o && r_ready_i;

    // NOTE: every process that writes state uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        ar_ready_o = 1'b0;
        mem_req_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ar_ready_o = 1'b1;
                if (ar_valid_i) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                mem_req_o = can_issue;
                if (can_issue && mem_gnt_i && (beat_cnt_q == 8'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // WRAP keeps the upper address bits and wraps the low bits inside a
    // (len+1) << size byte window.
    always_comb begin
        addr_step = AddrWidth'(1) << size_q;
        addr_incr = addr_q + addr_step;
        wrap_mask = (AddrWidth'({1'b0, len_q} + 9'd1) << size_q) - AddrWidth'(1);
        unique case (burst_q)
            2'b00:   addr_next = addr_q;
            2'b10:   addr_next = (addr_q & ~wrap_mask) | (addr_incr & wrap_mask);
            default: addr_next = addr_incr;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            user_q     <= '0;
        end else if (ar_hs) begin
            id_q       <= ar_id_i;
            addr_q     <= ar_addr_i;
            len_q      <= ar_len_i;
            beat_cnt_q <= ar_len_i;
            size_q     <= ar_size_i;
            burst_q    <= ar_burst_i;
            user_q     <= ar_user_i;
        end else if (issue) begin
            addr_q     <= addr_next;
            beat_cnt_q <= beat_cnt_q - 8'd1;
        end
    end

    assign mem_addr_o = addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else if (issue && !r_hs) begin
            outstanding_q <= outstanding_q + CntWidth'(1);
        end else if (r_hs && !issue) begin
            outstanding_q <= outstanding_q - CntWidth'(1);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and counts are, and
    // the output gating below keeps unwritten entries from being visible.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            meta_mem[meta_wr_q] <= {id_q, user_q, beat_cnt_q == 8'd0};
        end
        if (mem_rvalid_i) begin
            resp_mem[resp_wr_q] <= {mem_rdata_i, mem_err_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_wr_q  <= '0;
            meta_rd_q  <= '0;
            resp_wr_q  <= '0;
            resp_rd_q  <= '0;
            resp_cnt_q <= '0;
        end else begin
            if (issue) begin
                meta_wr_q <= meta_wr_q + PtrWidth'(1);
            end
            if (mem_rvalid_i) begin
                resp_wr_q <= resp_wr_q + PtrWidth'(1);
            end
            if (r_hs) begin
                meta_rd_q <= meta_rd_q + PtrWidth'(1);
                resp_rd_q <= resp_rd_q + PtrWidth'(1);
            end
            if (mem_rvalid_i && !r_hs) begin
                resp_cnt_q <= resp_cnt_q + CntWidth'(1);
            end else if (r_hs && !mem_rvalid_i) begin
                resp_cnt_q <= resp_cnt_q - CntWidth'(1);
            end
        end
    end

    // Metadata is always pushed before its data arrives, so both heads line up.
    assign {r_id_o, r_user_o, meta_last} = meta_mem[meta_rd_q];
    assign {r_data_o, resp_err}          = resp_mem[resp_rd_q];

    assign r_valid_o = (resp_cnt_q != '0);
    assign r_last_o  = r_valid_o && meta_last;
    assign r_resp_o  = (r_valid_o && resp_err) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_to_mem_r_beat_gen.sv
// Directed bench for axi_to_mem_r_beat_gen: a vector table of bursts plus hand-written
// sequences for backpressure, back-to-back descriptors and reset in mid-burst.
module tb_axi_to_mem_r_beat_gen;

    localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;
    localparam logic [31:0] NO_ERR   = 32'hDEAD_BEEF;

    logic        clk_i;
    logic        rst_ni;
    logic        ar_valid_i;
    logic        ar_ready_o;
    logic [3:0]  ar_id_i;
    logic [31:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic [2:0]  ar_size_i;
    logic [1:0]  ar_burst_i;
    logic [0:0]  ar_user_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        r_valid_o;
    logic        r_ready_i;
    logic [3:0]  r_id_o;
    logic [31:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic [0:0]  r_user_o;

    axi_to_mem_r_beat_gen #(
        .DataWidth      (32),
        .AddrWidth      (32),
        .IdWidth        (4),
        .UserWidth      (1),
        .MaxOutstanding (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ar_valid_i   (ar_valid_i),
        .ar_ready_o   (ar_ready_o),
        .ar_id_i      (ar_id_i),
        .ar_addr_i    (ar_addr_i),
        .ar_len_i     (ar_len_i),
        .ar_size_i    (ar_size_i),
        .ar_burst_i   (ar_burst_i),
        .ar_user_i    (ar_user_i),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i),
        .r_valid_o    (r_valid_o),
        .r_ready_i    (r_ready_i),
        .r_id_o       (r_id_o),
        .r_data_o     (r_data_o),
        .r_resp_o     (r_resp_o),
        .r_last_o     (r_last_o),
        .r_user_o     (r_user_o)
    );

    typedef struct {
        logic [3:0]        id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              user;
        int                err_idx;
        logic              stall;
        logic [7:0][31:0]  exp_addr;
    } vec_t;

    int n_cmp;
    int n_fail;

    logic [31:0] err_addr;
    logic        stall_mode;

    int          n_addr;
    int          n_beat;
    logic [31:0] got_addr [16];
    logic [3:0]  got_id   [16];
    logic [31:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    logic        got_user [16];

    vec_t vecs [8];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // One-cycle-latency memory: a grant seen in cycle N returns data in cycle N+1.
    initial begin : mem_model
        logic        pend;
        logic        pend_err;
        logic [31:0] pend_addr;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_err_i    = 1'b0;
        mem_gnt_i    = 1'b1;
        pend         = 1'b0;
        pend_err     = 1'b0;
        pend_addr    = '0;
        forever begin
            @(negedge clk_i);
            pend      = rst_ni && mem_req_o && mem_gnt_i;
            pend_addr = mem_addr_o;
            pend_err  = (mem_addr_o == err_addr);
            @(posedge clk_i);
            #1;
            mem_rvalid_i = pend && rst_ni;
            mem_rdata_i  = pend ? (pend_addr ^ DATA_KEY) : '0;
            mem_err_i    = pend && pend_err;
            mem_gnt_i    = stall_mode ? ~mem_gnt_i : 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic record();
        if (mem_req_o && mem_gnt_i && n_addr < 16) begin
            got_addr[n_addr] = mem_addr_o;
            n_addr++;
        end
        if (r_valid_o && r_ready_i && n_beat < 16) begin
            got_id[n_beat]   = r_id_o;
            got_data[n_beat] = r_data_o;
            got_resp[n_beat] = r_resp_o;
            got_last[n_beat] = r_last_o;
            got_user[n_beat] = r_user_o[0];
            n_beat++;
        end
    endtask

    task automatic collect(input int need, input int budget);
        int cyc;
        cyc = 0;
        while (n_beat < need && cyc < budget) begin
            @(negedge clk_i);
            record();
            step();
            cyc++;
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic user);
        ar_id_i    = id;
        ar_addr_i  = addr;
        ar_len_i   = len;
        ar_size_i  = size;
        ar_burst_i = burst;
        ar_user_i  = user;
        ar_valid_i = 1'b1;
        @(negedge clk_i);
        check($sformatf("ar_ready_id%0d", id), 64'(ar_ready_o), 64'(1));
        record();
        step();
        ar_valid_i = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [3:0] id, input logic user, input int len,
                          input logic [7:0][31:0] ea, input int err_idx);
        check({tag, "_nbeat"}, 64'(n_beat), 64'(len + 1));
        check({tag, "_ngrant"}, 64'(n_addr), 64'(len + 1));
        for (int i = 0; i <= len && i < n_beat && i < n_addr; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(ea[i]));
            check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(ea[i] ^ DATA_KEY));
            check($sformatf("%s_id%0d", tag, i), 64'(got_id[i]), 64'(id));
            check($sformatf("%s_user%0d", tag, i), 64'(got_user[i]), 64'(user));
            check($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == len));
            check($sformatf("%s_resp%0d", tag, i), 64'(got_resp[i]), (i == err_idx) ? 64'(2) : 64'(0));
        end
    endtask

    function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input logic user,
                                input int err_idx, input logic stall,
                                input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        vec_t v;
        v.id          = id;
        v.addr        = addr;
        v.len         = len;
        v.size        = size;
        v.burst       = burst;
        v.user        = user;
        v.err_idx     = err_idx;
        v.stall       = stall;
        v.exp_addr[0] = a0;
        v.exp_addr[1] = a1;
        v.exp_addr[2] = a2;
        v.exp_addr[3] = a3;
        v.exp_addr[4] = a4;
        v.exp_addr[5] = a5;
        v.exp_addr[6] = a6;
        v.exp_addr[7] = a7;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        stall_mode = v.stall;
        err_addr   = (v.err_idx >= 0) ? v.exp_addr[v.err_idx] : NO_ERR;
        n_addr     = 0;
        n_beat     = 0;
        send_ar(v.id, v.addr, v.len, v.size, v.burst, v.user);
        collect(int'(v.len) + 1, 200);
        verify(tag, v.id, v.user, int'(v.len), v.exp_addr, v.err_idx);
        stall_mode = 1'b0;
        err_addr   = NO_ERR;
        step();
    endtask

    initial begin : main
        logic [7:0][31:0] ea;
        logic [3:0]       b2b_id   [3];
        logic             b2b_last [3];
        logic [31:0]      b2b_addr [3];

        n_cmp      = 0;
        n_fail     = 0;
        rst_ni     = 1'b0;
        ar_valid_i = 1'b0;
        ar_id_i    = '0;
        ar_addr_i  = '0;
        ar_len_i   = '0;
        ar_size_i  = '0;
        ar_burst_i = '0;
        ar_user_i  = '0;
        r_ready_i  = 1'b1;
        err_addr   = NO_ERR;
        stall_mode = 1'b0;
        n_addr     = 0;
        n_beat     = 0;

        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ar_ready", 64'(ar_ready_o), 64'(1));
        check("rst_mem_req", 64'(mem_req_o), 64'(0));
        check("rst_r_valid", 64'(r_valid_o), 64'(0));
        check("rst_r_last", 64'(r_last_o), 64'(0));
        check("rst_r_resp", 64'(r_resp_o), 64'(0));
        rst_ni = 1'b1;
        step();

        //         id     addr          len   size  burst  user  err stall  expected beat addresses
        vecs[0] = mk(4'd3,  32'h0000_0100, 8'd3, 3'd2, 2'b01, 1'b0, -1, 1'b0,
                     32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0);
        vecs[1] = mk(4'd5,  32'h0000_010C, 8'd3, 3'd2, 2'b10, 1'b1, -1, 1'b1,
                     32'h10C, 32'h100, 32'h104, 32'h108, 0, 0, 0, 0);
        vecs[2] = mk(4'd7,  32'h0000_0040, 8'd2, 3'd2, 2'b00, 1'b0, -1, 1'b0,
                     32'h40, 32'h40, 32'h40, 0, 0, 0, 0, 0);
        vecs[3] = mk(4'd9,  32'h0000_0200, 8'd1, 3'd3, 2'b11, 1'b1, -1, 1'b0,
                     32'h200, 32'h208, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(4'd2,  32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 1'b0, -1, 1'b0,
                     32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0, 0);
        vecs[5] = mk(4'd6,  32'h0000_0035, 8'd7, 3'd0, 2'b10, 1'b1, -1, 1'b1,
                     32'h35, 32'h36, 32'h37, 32'h30, 32'h31, 32'h32, 32'h33, 32'h34);
        vecs[6] = mk(4'd15, 32'h0000_0080, 8'd0, 3'd2, 2'b01, 1'b1, -1, 1'b0,
                     32'h80, 0, 0, 0, 0, 0, 0, 0);
        vecs[7] = mk(4'd12, 32'h0000_0500, 8'd3, 3'd2, 2'b01, 1'b0, 2, 1'b0,
                     32'h500, 32'h504, 32'h508, 32'h50C, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: four grants, then the requester stalls until an R handshake.
        n_addr    = 0;
        n_beat    = 0;
        r_ready_i = 1'b0;
        send_ar(4'd4, 32'h400, 8'd7, 3'd2, 2'b01, 1'b0);
        repeat (12) begin
            @(negedge clk_i);
            record();
            step();
        end
        check("bp_grants", 64'(n_addr), 64'(4));
        @(negedge clk_i);
        check("bp_req_low", 64'(mem_req_o), 64'(0));
        check("bp_r_valid", 64'(r_valid_o), 64'(1));
        check("bp_head_stable", 64'(r_data_o), 64'(32'h400 ^ DATA_KEY));
        step();
        r_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_req_during_hs", 64'(mem_req_o), 64'(0));
        record();
        step();
        r_ready_i = 1'b0;
        @(negedge clk_i);
        check("bp_req_resume", 64'(mem_req_o), 64'(1));
        record();
        step();
        r_ready_i = 1'b1;
        collect(8, 200);
        for (int i = 0; i < 8; i++) begin
            ea[i] = 32'h400 + 32'(4 * i);
        end
        verify("bp", 4'd4, 1'b0, 7, ea, -1);
        step();

        // Back-to-back descriptors: len 0 then len 1.
        n_addr = 0;
        n_beat = 0;
        send_ar(4'd1, 32'h600, 8'd0, 3'd2, 2'b01, 1'b0);
        @(negedge clk_i);
        check("b2b_busy", 64'(ar_ready_o), 64'(0));
        record();
        step();
        send_ar(4'd2, 32'h700, 8'd1, 3'd2, 2'b01, 1'b0);
        @(negedge clk_i);
        check("b2b_no_bubble", 64'(mem_req_o), 64'(1));
        record();
        step();
        collect(3, 200);
        b2b_id   = '{4'd1, 4'd2, 4'd2};
        b2b_last = '{1'b1, 1'b0, 1'b1};
        b2b_addr = '{32'h600, 32'h700, 32'h704};
        check("b2b_nbeat", 64'(n_beat), 64'(3));
        for (int i = 0; i < 3 && i < n_beat; i++) begin
            check($sformatf("b2b_id%0d", i), 64'(got_id[i]), 64'(b2b_id[i]));
            check($sformatf("b2b_last%0d", i), 64'(got_last[i]), 64'(b2b_last[i]));
            check($sformatf("b2b_data%0d", i), 64'(got_data[i]), 64'(b2b_addr[i] ^ DATA_KEY));
        end
        step();

        // Reset while the third beat of an eight-beat burst is due.
        n_addr = 0;
        n_beat = 0;
        send_ar(4'd8, 32'h800, 8'd7, 3'd2, 2'b01, 1'b1);
        repeat (2) begin
            @(negedge clk_i);
            record();
            step();
        end
        check("mid_grants", 64'(n_addr), 64'(2));
        rst_ni = 1'b0;
        #1;
        check("mid_rst_ar_ready", 64'(ar_ready_o), 64'(1));
        check("mid_rst_mem_req", 64'(mem_req_o), 64'(0));
        check("mid_rst_r_valid", 64'(r_valid_o), 64'(0));
        check("mid_rst_r_last", 64'(r_last_o), 64'(0));
        check("mid_rst_r_resp", 64'(r_resp_o), 64'(0));
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        @(negedge clk_i);
        check("post_rst_r_valid", 64'(r_valid_o), 64'(0));
        check("post_rst_mem_req", 64'(mem_req_o), 64'(0));
        step();
        run_vec(vecs[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_to_mem_r_beat_gen.md
AXI_TO_MEM_R_BEAT_GEN -- requirements
Module: axi_to_mem_r_beat_gen

Interface
REQ-001 Parameter DataWidth, default 32: width of the memory word and of R data.
REQ-002 Parameter AddrWidth, default 32: width of the byte address.
REQ-003 Parameter IdWidth, default 4: AXI ID width.
REQ-004 Parameter UserWidth, default 1: AXI user width.
REQ-005 Parameter MaxOutstanding, default 4 (power of 2, ≥2): maximum number of beats that have been granted but not yet accepted on R.
REQ-006 The block's clock is clk_i and its reset is rst_ni, asynchronous, active-low. Port list, clock and reset first:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ar_valid_i  in  1  read burst descriptor valid
- ar_ready_o  out  1  descriptor accepted
- ar_id_i / ar_addr_i / ar_len_i / ar_size_i / ar_burst_i / ar_user_i  in  IdWidth / AddrWidth / 8 / 3 / 2 / UserWidth  AXI AR fields
- mem_req_o  out  1  memory read request
- mem_gnt_i  in  1  request granted
- mem_addr_o  out  AddrWidth  beat byte address
- mem_rvalid_i  in  1  read data valid, in grant order, no backpressure
- mem_rdata_i  in  DataWidth  read data
- mem_err_i  in  1  access error, qualified by mem_rvalid_i
- r_valid_o  out  1  R beat valid
- r_ready_i  in  1  R beat accepted
- r_id_o / r_data_o / r_resp_o / r_last_o / r_user_o  out  IdWidth / DataWidth / 2 / 1 / UserWidth  R beat fields

Function
REQ-007 The FSM SHALL have states IDLE and BURST; ar_ready_o SHALL be 1 only in IDLE.
REQ-008 On ar_valid_i && ar_ready_o, the block SHALL latch id, addr, len, size, burst and user, load the beat counter with ar_len_i, and go to BURST in the next cycle.
REQ-009 In BURST, mem_req_o SHALL be 1 when outstanding < MaxOutstanding; mem_addr_o SHALL be the current beat address.
REQ-010 A beat SHALL be issued on mem_req_o && mem_gnt_i; at issue, {id, user, last = (beat counter == 0)} SHALL be pushed to an internal metadata FIFO of depth MaxOutstanding.
REQ-011 After the issue of the beat with counter 0, the FSM SHALL return to IDLE; a new AR SHALL be accepted the next cycle, with no bubble beyond that.
REQ-012 Address update after each issued beat: FIXED (2'b00) unchanged; INCR (2'b01) addr + (1 << size); WRAP (2'b10) addr + (1 << size), wrapped to the aligned boundary of size (len+1) << size; burst 2'b11 SHALL be treated as INCR.
REQ-013 Address arithmetic SHALL be AddrWidth wide and wrap modulo 2^AddrWidth with no error.
REQ-014 mem_rvalid_i data SHALL be written into a response FIFO of depth MaxOutstanding; because of REQ-009, that FIFO never overflows, including when a write and a pop occur in the same cycle.
REQ-015 r_valid_o SHALL be 1 when the response FIFO is non-empty; the R fields SHALL come from the heads of both FIFOs.
REQ-016 r_resp_o SHALL be 2'b10 (SLVERR) if the stored err is 1, else 2'b00.
REQ-017 Both FIFO heads SHALL pop on r_valid_o && r_ready_i; the R fields SHALL stay stable while r_valid_o && !r_ready_i.
REQ-018 The outstanding counter (log2(MaxOutstanding)+1 bits) SHALL increment on issue and decrement on R handshake; when both happen in one cycle it SHALL hold.
REQ-019 Minimum latency: mem_rvalid_i in cycle N gives r_valid_o in cycle N+1 (registered storage, no fall-through).
REQ-020 With MaxOutstanding outstanding and r_ready_i held at 0, mem_req_o SHALL stay 0; request issue SHALL resume the cycle after an R handshake.

Reset
REQ-021 On rst_ni low, the FSM SHALL go to IDLE, and all counters, FIFO pointers and outstanding SHALL clear. Outputs during reset: ar_ready_o=1, mem_req_o=0, r_valid_o=0, r_last_o=0, r_resp_o=0.
REQ-022 Reset during BURST SHALL abandon the burst; memory responses arriving after reset release SHALL not be required to be handled (the environment flushes memory too).

Verification
REQ-023 INCR burst: addr=0x100, len=3, size=2, 1-cycle memory latency, r_ready_i=1 -> mem_addr_o 0x100, 0x104, 0x108, 0x10C; 4 R beats, r_last_o only on the 4th, resp=00.
REQ-024 WRAP burst: addr=0x10C, len=3, size=2 -> mem_addr_o 0x10C, 0x100, 0x104, 0x108.
REQ-025 Backpressure: MaxOutstanding=4, len=7, r_ready_i=0 -> exactly 4 grants, then mem_req_o=0; r_ready_i=1 -> all 8 beats delivered in order, no loss.
REQ-026 Error: mem_err_i=1 on beat 2 of len=3 -> that beat has r_resp_o=2'b10 and the others 2'b00; r_last_o is unaffected.
REQ-027 Back-to-back ARs: len=0 with id=1, then len=1 with id=2 -> ar_ready_o is 1 again 2 cycles after the first accept; 3 beats with ids 1, 2, 2 and last flags 1, 0, 1.
REQ-028 Reset mid-burst: rst_ni pulsed during beat 2 of len=7 -> outputs at their reset values, and the next AR completes normally.
